// File: rtl/griffin_round_sequencer.sv
// Round sequencer for the single-round Griffin core: runs NUM_ROUNDS rounds per
// permutation, addresses the constant ROM and aborts a stalled round via a watchdog.
module griffin_round_sequencer #(
    parameter int N_BITS     = 254,
    parameter int STATE_SIZE = 3,
    parameter int NUM_ROUNDS = 16,
    parameter int RC_ADDR_W  = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
    parameter int TIMEOUT    = 4096
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [STATE_SIZE-1:0][N_BITS-1:0]   in_state,
    output logic                                busy,
    output logic [STATE_SIZE-1:0][N_BITS-1:0]   out_state,
    output logic                                out_valid,
    output logic                                error,
    output logic [RC_ADDR_W-1:0]                rc_addr,
    input  logic [STATE_SIZE-1:0][N_BITS-1:0]   rc_data,
    output logic                                round_enable,
    output logic [STATE_SIZE-1:0][N_BITS-1:0]   round_state,
    output logic [STATE_SIZE-1:0][N_BITS-1:0]   round_constants,
    input  logic [STATE_SIZE-1:0][N_BITS-1:0]   round_result,
    input  logic                                round_done
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]      WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [RC_ADDR_W-1:0] LAST_ROUND = RC_ADDR_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [WD_W-1:0]        watchdog;
    logic [RC_ADDR_W-1:0]   round_idx;

    logic accept;
    logic last_done;
    logic more_done;
    logic expire;

    // round_done wins over watchdog expiry when both land in the same cycle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_done  = 1'b0;
        more_done  = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (round_done) begin
                    if (round_idx == LAST_ROUND) begin
                        last_done  = 1'b1;
                        state_next = FINISH;
                    end else begin
                        more_done  = 1'b1;
                        state_next = ISSUE;
                    end
                end else if (watchdog == WD_LAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_enable    <= 1'b0;
            round_state     <= '0;
            round_constants <= '0;
            out_state       <= '0;
            round_idx       <= '0;
            watchdog        <= '0;
            error           <= 1'b0;
        end else begin
            round_enable <= (state == ISSUE);
            if (accept) begin
                round_state <= in_state;
                round_idx   <= '0;
                error       <= 1'b0;
            end
            if (state == ISSUE) begin
                round_constants <= rc_data;
                watchdog        <= '0;
            end
            // Result feeds back as the next round's input; the counter doubles as ROM address
            if (last_done || more_done) begin
                round_state <= round_result;
            end
            if (last_done) begin
                out_state <= round_result;
            end
            if (more_done) begin
                round_idx <= round_idx + 1'b1;
            end
            if (state == WAIT && !round_done) begin
                if (expire) begin
                    error <= 1'b1;
                end else begin
                    watchdog <= watchdog + 1'b1;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == FINISH);
    assign rc_addr   = round_idx;

endmodule

// File: tb/tb_griffin_round_sequencer.sv
// Bench for griffin_round_sequencer: an adder stub core with programmable latency,
// a random constant ROM and a reference model built from the round/latency rules.
module tb_griffin_round_sequencer;

    localparam int N_BITS     = 254;
    localparam int STATE_SIZE = 3;
    localparam int NUM_ROUNDS = 3;
    localparam int RC_ADDR_W  = 2;
    localparam int TIMEOUT    = 8;

    typedef logic [STATE_SIZE-1:0][N_BITS-1:0] vec_t;

    logic                 clk;
    logic                 reset;
    logic                 start;
    vec_t                 in_state;
    logic                 busy;
    vec_t                 out_state;
    logic                 out_valid;
    logic                 error;
    logic [RC_ADDR_W-1:0] rc_addr;
    vec_t                 rc_data;
    logic                 round_enable;
    vec_t                 round_state;
    vec_t                 round_constants;
    vec_t                 round_result;
    logic                 round_done;

    griffin_round_sequencer #(
        .N_BITS(N_BITS),
        .STATE_SIZE(STATE_SIZE),
        .NUM_ROUNDS(NUM_ROUNDS),
        .RC_ADDR_W(RC_ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_state(in_state),
        .busy(busy),
        .out_state(out_state),
        .out_valid(out_valid),
        .error(error),
        .rc_addr(rc_addr),
        .rc_data(rc_data),
        .round_enable(round_enable),
        .round_state(round_state),
        .round_constants(round_constants),
        .round_result(round_result),
        .round_done(round_done)
    );

    vec_t rom [4];
    assign rc_data = rom[rc_addr];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int t0 = 0;

    int   en_cycles [$];
    int   en_addrs  [$];
    int   ov_cycles [$];
    vec_t ov_states [$];
    int   busy_cycles [$];
    int   err_cycles  [$];

    int   stub_delay = 5;
    logic stub_force = 1'b0;
    logic stub_pending = 1'b0;
    int   stub_cnt = 0;
    vec_t stub_result;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Stub round core: result = state + constants, done D cycles after the enable cycle
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            stub_pending = 1'b0;
            stub_cnt     = 0;
            round_done   = 1'b0;
        end else begin
            round_done = 1'b0;
            if (stub_force) begin
                round_done   = 1'b1;
                round_result = {STATE_SIZE{{(N_BITS/2){2'b01}}}};
            end
            if (round_enable) begin
                stub_pending = 1'b1;
                stub_cnt     = 0;
                for (int i = 0; i < STATE_SIZE; i++)
                    stub_result[i] = round_state[i] + round_constants[i];
            end
            if (stub_pending) begin
                if (stub_cnt == stub_delay) begin
                    round_done   = 1'b1;
                    round_result = stub_result;
                    stub_pending = 1'b0;
                end else begin
                    stub_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (round_enable) begin
                en_cycles.push_back(cyc);
                en_addrs.push_back(int'(rc_addr));
            end
            if (out_valid) begin
                ov_cycles.push_back(cyc);
                ov_states.push_back(out_state);
            end
            if (busy) busy_cycles.push_back(cyc);
            if (error) err_cycles.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [N_BITS-1:0] randElem();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[N_BITS-1:0];
    endfunction

    function automatic vec_t randVec();
        vec_t v;
        for (int i = 0; i < STATE_SIZE; i++) v[i] = randElem();
        return v;
    endfunction

    // Each round adds its constants, so the permutation is input plus all constants
    function automatic vec_t modelOut(input vec_t st);
        vec_t v;
        v = st;
        for (int r = 0; r < NUM_ROUNDS; r++)
            for (int i = 0; i < STATE_SIZE; i++)
                v[i] = v[i] + rom[r][i];
        return v;
    endfunction

    task automatic clearLogs();
        en_cycles.delete();
        en_addrs.delete();
        ov_cycles.delete();
        ov_states.delete();
        busy_cycles.delete();
        err_cycles.delete();
    endtask

    task automatic applyStimulus(input vec_t st, input int delay);
        @(negedge clk);
        clearLogs();
        stub_delay = delay;
        in_state   = st;
        start      = 1'b1;
        t0         = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkRun(input string name, input vec_t st, input int delay);
        vec_t exp_out;
        int   period;
        exp_out = modelOut(st);
        period  = delay + 2;
        checkOutput({name, "_ov_count"}, ov_cycles.size(), 1);
        if (ov_cycles.size() > 0) begin
            checkOutput({name, "_ov_cycle"}, ov_cycles[0] - t0, NUM_ROUNDS * period + 1);
            for (int i = 0; i < STATE_SIZE; i++)
                checkOutput({name, "_out_state"}, ov_states[0][i], exp_out[i]);
        end
        checkOutput({name, "_en_count"}, en_cycles.size(), NUM_ROUNDS);
        for (int r = 0; r < NUM_ROUNDS && r < en_cycles.size(); r++) begin
            checkOutput({name, "_en_cycle"}, en_cycles[r] - t0, 2 + r * period);
            checkOutput({name, "_rc_addr"}, en_addrs[r], r);
        end
        checkOutput({name, "_busy_count"}, busy_cycles.size(), NUM_ROUNDS * period + 1);
        if (busy_cycles.size() > 0)
            checkOutput({name, "_busy_first"}, busy_cycles[0] - t0, 1);
        checkOutput({name, "_error"}, error, 0);
    endtask

    initial begin
        vec_t st;
        vec_t exp_out;
        int   d;

        reset    = 1'b1;
        start    = 1'b0;
        in_state = '0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < STATE_SIZE; i++)
                rom[r][i] = N_BITS'(r + 1);

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_round_enable", round_enable, 0);
        checkOutput("rst_rc_addr", rc_addr, 0);
        checkOutput("rst_round_state", round_state, 0);
        checkOutput("rst_round_constants", round_constants, 0);
        checkOutput("rst_out_state", out_state, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed run with an ignored start re-pulse in cycle 10
        for (int i = 0; i < STATE_SIZE; i++) st[i] = N_BITS'(i + 1);
        applyStimulus(st, 5);
        repeat (9) @(negedge clk);
        in_state = {STATE_SIZE{N_BITS'(9)}};
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checkRun("directed", st, 5);
        if (ov_cycles.size() > 0) begin
            checkOutput("directed_out0", ov_states[0][0], 7);
            checkOutput("directed_out2", ov_states[0][2], 9);
        end
        if (busy_cycles.size() > 0)
            checkOutput("directed_busy_last", busy_cycles[$] - t0, 22);

        // Back-to-back with start held high
        @(negedge clk);
        clearLogs();
        stub_delay = 5;
        in_state   = st;
        start      = 1'b1;
        t0         = cyc;
        repeat (24) @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        checkOutput("b2b_ov_count", ov_cycles.size(), 2);
        if (ov_cycles.size() > 1) begin
            checkOutput("b2b_ov_first", ov_cycles[0] - t0, 22);
            checkOutput("b2b_ov_second", ov_cycles[1] - t0, 45);
            checkOutput("b2b_out1", ov_states[1][1], 8);
        end
        checkOutput("b2b_busy_count", busy_cycles.size(), 44);

        // Watchdog abort, then the next start clears error
        st = randVec();
        applyStimulus(st, 100);
        repeat (13) @(negedge clk);
        checkOutput("to_ov_count", ov_cycles.size(), 0);
        checkOutput("to_error", error, 1);
        checkOutput("to_en_count", en_cycles.size(), 1);
        if (err_cycles.size() > 0)
            checkOutput("to_error_cycle", err_cycles[0] - t0, 10);
        else
            checkOutput("to_error_seen", 0, 1);
        if (busy_cycles.size() > 0)
            checkOutput("to_busy_last", busy_cycles[$] - t0, 9);
        st = randVec();
        for (int r = 0; r < NUM_ROUNDS; r++) rom[r] = randVec();
        applyStimulus(st, 3);
        checkOutput("to_error_cleared", error, 0);
        repeat (30) @(negedge clk);
        checkRun("after_to", st, 3);

        // round_done in the watchdog-expiry cycle counts as completion
        st = randVec();
        applyStimulus(st, TIMEOUT - 1);
        repeat (35) @(negedge clk);
        checkRun("expiry_done", st, TIMEOUT - 1);

        // Reset during the enable cycle of round 1, then a spurious round_done
        st = randVec();
        applyStimulus(st, 5);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_round_enable", round_enable, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rc_addr", rc_addr, 0);
        checkOutput("mid_rst_round_state", round_state, 0);
        checkOutput("mid_rst_out_state", out_state, 0);
        @(negedge clk);
        reset = 1'b0;
        clearLogs();
        stub_force = 1'b1;
        @(negedge clk);
        stub_force = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("spur_en_count", en_cycles.size(), 0);
        checkOutput("spur_ov_count", ov_cycles.size(), 0);
        checkOutput("spur_busy_count", busy_cycles.size(), 0);
        checkOutput("spur_round_state", round_state, 0);

        // Random runs over the full completion range 0..TIMEOUT-1
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < NUM_ROUNDS; r++) rom[r] = randVec();
            st = randVec();
            d  = $urandom_range(0, TIMEOUT - 1);
            applyStimulus(st, d);
            repeat (NUM_ROUNDS * (d + 2) + 6) @(negedge clk);
            checkRun("random", st, d);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
